// File: rtl/gaxi_arb_pkg.sv
// Shared types and helpers for the GAXI round-robin arbiter.
package gaxi_arb_pkg;

    typedef enum logic [0:0] {ARB_IDLE, ARB_XFER} arb_state_t;

    function automatic int arb_id_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gaxi_arb_rr_pick.sv
// Rotating-priority picker: first set request strictly after last_grant, wrapping.
module gaxi_arb_rr_pick
    import gaxi_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDW     = arb_id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     last_grant,
    output logic               found,
    output logic [IDW-1:0]     grant_idx
);

    logic [IDW-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is written last.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDW'((int'(last_grant) + k) % NUM_REQ);
            if (req[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

endmodule

// File: rtl/gaxi_rr_arbiter_multi.sv
// Round-robin arbiter sharing one registered addr/ctrl/data0/data1 GAXI channel
// among NUM_REQ requesters, with a bounded burst per grant.
module gaxi_rr_arbiter_multi
    import gaxi_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int CTRL_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_MAX  = 4,
    localparam int IDW       = arb_id_width(NUM_REQ)
) (
    input  logic                           axi_aclk,
    input  logic                           axi_areset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*CTRL_WIDTH-1:0]  req_ctrl,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data0,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data1,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ADDR_WIDTH-1:0]          out_addr,
    output logic [CTRL_WIDTH-1:0]          out_ctrl,
    output logic [DATA_WIDTH-1:0]          out_data0,
    output logic [DATA_WIDTH-1:0]          out_data1,
    output logic [IDW-1:0]                 out_id,
    output logic                           grant_active
);

    localparam int BCW = arb_id_width(BURST_MAX);
    localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST_MAX - 1);

    arb_state_t      state;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  last_grant;
    logic [BCW-1:0]  beat_cnt;
    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            xfer_rdy;
    logic            cur_valid;
    logic            accept;

    gaxi_arb_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_pick (
        .req        (req_valid),
        .last_grant (last_grant),
        .found      (pick_found),
        .grant_idx  (pick_idx)
    );

    // Ready only reaches the granted requester, and only when the output slot frees.
    assign xfer_rdy  = (state == ARB_XFER) && (!out_valid || out_ready);
    assign cur_valid = req_valid[grant_id];
    assign accept    = xfer_rdy && cur_valid;

    always_comb begin
        req_ready = '0;
        if (xfer_rdy)
            req_ready[grant_id] = 1'b1;
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            state        <= ARB_IDLE;
            grant_id     <= '0;
            last_grant   <= IDW'(NUM_REQ - 1);
            beat_cnt     <= '0;
            grant_active <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_found) begin
                        grant_id     <= pick_idx;
                        last_grant   <= pick_idx;
                        state        <= ARB_XFER;
                        grant_active <= 1'b1;
                    end
                end
                ARB_XFER: begin
                    // A dropped valid ends the grant even while stalled.
                    if (!cur_valid || (accept && beat_cnt == BEAT_LAST)) begin
                        state        <= ARB_IDLE;
                        grant_active <= 1'b0;
                        beat_cnt     <= '0;
                    end else if (accept) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                end
                default: begin
                    state        <= ARB_IDLE;
                    grant_active <= 1'b0;
                    beat_cnt     <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            out_valid <= 1'b0;
            out_addr  <= '0;
            out_ctrl  <= '0;
            out_data0 <= '0;
            out_data1 <= '0;
            out_id    <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_addr  <= req_addr [grant_id*ADDR_WIDTH +: ADDR_WIDTH];
            out_ctrl  <= req_ctrl [grant_id*CTRL_WIDTH +: CTRL_WIDTH];
            out_data0 <= req_data0[grant_id*DATA_WIDTH +: DATA_WIDTH];
            out_data1 <= req_data1[grant_id*DATA_WIDTH +: DATA_WIDTH];
            out_id    <= grant_id;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
